fb_bank_scheduler: RTL
======================

Name: fb_bank_scheduler

Overview:
- Ping-pong scheduler for the two 1-bit plot framebuffer BRAMs (bank 0 / bank 1) of the HDMI path.
- One bank is the display bank, owned by the pixel reader. The other is the draw bank, which the cleaner erases and then the trace writer plots into.
- At each frame start, banks swap only if the draw bank is complete and display is not held.
- Single clock domain; it sits between the writer/cleaner/reader engines and the BRAMs.

Parameters:
- ADDR_WIDTH, 19, BRAM address width (1024x512 pixels).
- CNT_WIDTH, 16, width of the swap and late-frame counters.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- hold  in  1  1 = freeze display (suppress swaps).
- clean_valid  in  1  cleaner presents clean_addr.
- clean_addr  in  ADDR_WIDTH  pixel to erase.
- clean_last  in  1  final clean beat (qualified by clean_valid).
- wr_valid  in  1  writer presents wr_addr/wr_data.
- wr_addr  in  ADDR_WIDTH  pixel to plot.
- wr_data  in  1  pixel value.
- wr_last  in  1  final write beat (qualified by wr_valid).
- rd_en  in  1  reader access to display bank.
- rd_addr  in  ADDR_WIDTH  display read address.
- rd0, rd1  in  1  BRAM read data, 1-cycle latency.
- en0, we0  out  1  bank 0 enable / write enable.
- addr0  out  ADDR_WIDTH  bank 0 address.
- en1, we1  out  1  bank 1 enable / write enable.
- addr1  out  ADDR_WIDTH  bank 1 address.
- wd  out  1  write data, shared by both banks.
- rd_data  out  1  display pixel, valid 1 cycle after rd_en.
- clean_go  out  1  level: cleaner may run.
- write_go  out  1  level: writer may run.
- disp_bank  out  1  current display bank.
- state  out  2  CLEAN=0, WRITE=1, READY=2.
- swap_cnt  out  CNT_WIDTH  completed swaps.
- late_cnt  out  CNT_WIDTH  frame_starts with no swap because the draw bank was not READY (hold=0 only).

Behaviour:
- Reset (rst_n=0, async): state=CLEAN, disp_bank=0, rd_sel=0, swap_cnt=0, late_cnt=0. While rst_n=0, en*/we*=0, wd=0, rd_data=0.
- clean_go=(state==CLEAN); write_go=(state==WRITE).
- Bank port mux is combinational from the registered state and disp_bank, zero added latency.
- Display bank: en=rd_en, we=0, addr=rd_addr.
- Draw bank in CLEAN: en=we=clean_valid, addr=clean_addr, wd=0.
- Draw bank in WRITE: en=we=wr_valid, addr=wr_addr, wd=wr_data.
- Draw bank in READY: en=we=0.
- Idle bank outputs: addr=0, wd=0.
- clean_valid outside CLEAN and wr_valid outside WRITE are ignored; no BRAM access.
- FSM transitions:
  - CLEAN -> WRITE on clean_valid&clean_last. That last beat is still written.
  - WRITE -> READY on wr_valid&wr_last. That last beat is still written.
  - READY -> CLEAN on frame_start&~hold; same edge toggles disp_bank and increments swap_cnt.
  - READY with hold=1 stays READY; no counter changes.
- Late frame: frame_start in CLEAN or WRITE with hold=0 increments late_cnt; state and bank are unchanged.
- Simultaneous events: frame_start with the wr_last beat goes to READY, no swap, late_cnt++. The swap waits for the next frame_start.
- Read data: rd_sel is disp_bank registered each cycle; rd_data = rd_sel ? rd1 : rd0. A read issued in the swap cycle returns the old bank's data.
- Counters wrap modulo 2^CNT_WIDTH.
- Reset mid-operation: any partial clean or write is abandoned. Restart is CLEAN on bank 1 (disp_bank=0).

Test Plan:
- Reset, then idle: en0=en1=we0=we1=0, state=0, clean_go=1, disp_bank=0; rd_en=1, rd_addr=5 -> en0=1, addr0=5, we0=0.
- Clean 4 beats (addr 0..3, last on 3): we1=1 with wd=0 each beat, state=1 after beat 3. Then write addr 2, data 1, last: we1=1, addr1=2, wd=1, state=2.
- From READY, pulse frame_start: disp_bank=1, state=0, swap_cnt=1. A read in the same cycle returns rd0; the next read returns rd1.
- frame_start during WRITE: late_cnt=1, disp_bank unchanged. frame_start in the same cycle as wr_last: state=2, late_cnt=2, no swap.
- hold=1 in READY with 3 frame_starts: swap_cnt and late_cnt unchanged, state=2. Drop hold, next frame_start -> swap_cnt+1.
- Assert rst_n=0 mid-WRITE: outputs at reset values immediately (asynchronous); release -> clean_go=1, draw bank 1.

Source files
------------

// File: rtl/fb_bank_scheduler.sv
// fb_bank_scheduler
//   Ping-pong scheduler for the two 1-bit plot framebuffer BRAMs.
//   One bank is the display bank, read by the pixel reader. The other is the
//   draw bank, which is cleaned and then plotted by the trace writer. At each
//   frame_start the banks swap, but only when the draw bank is READY and
//   display is not held.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   frame_start, hold               frame pulse, display freeze
//   clean_valid/addr/last           cleaner beat stream
//   wr_valid/addr/data/last         writer beat stream
//   rd_en, rd_addr, rd0, rd1        reader access, BRAM read data (1-cycle latency)
//   en0/we0/addr0, en1/we1/addr1    BRAM bank ports; wd is shared write data
//   rd_data                         display pixel, valid 1 cycle after rd_en
//   clean_go, write_go              engine run enables (levels)
//   disp_bank, state                current display bank, draw-bank FSM state
//   swap_cnt, late_cnt              completed swaps, frames missed by a late draw bank
module fb_bank_scheduler #(
  parameter int ADDR_WIDTH = 19,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  hold,
  input  logic                  clean_valid,
  input  logic [ADDR_WIDTH-1:0] clean_addr,
  input  logic                  clean_last,
  input  logic                  wr_valid,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  wr_data,
  input  logic                  wr_last,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd0,
  input  logic                  rd1,
  output logic                  en0,
  output logic                  we0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic                  en1,
  output logic                  we1,
  output logic [ADDR_WIDTH-1:0] addr1,
  output logic                  wd,
  output logic                  rd_data,
  output logic                  clean_go,
  output logic                  write_go,
  output logic                  disp_bank,
  output logic [1:0]            state,
  output logic [CNT_WIDTH-1:0]  swap_cnt,
  output logic [CNT_WIDTH-1:0]  late_cnt
);

  typedef enum logic [1:0] {CLEAN = 2'd0, WRITE = 2'd1, READY = 2'd2} state_t;

  state_t                 stateQ, stateD;
  logic                   dispBank, dispBankD;
  logic                   rdSel;
  logic [CNT_WIDTH-1:0]   swapCnt, lateCnt;
  logic                   swapNow, lateNow;

  logic                   drawEn, drawWe, drawWd;
  logic [ADDR_WIDTH-1:0]  drawAddr;

  // Next-state logic. A frame_start that arrives while the draw bank is still
  // being cleaned or written counts as late, even on the wr_last beat itself:
  // the bank becomes READY on that edge but the swap waits for the next frame.
  always_comb begin
    stateD    = stateQ;
    dispBankD = dispBank;
    swapNow   = 1'b0;
    lateNow   = 1'b0;
    unique case (stateQ)
      CLEAN: begin
        if (clean_valid && clean_last) stateD = WRITE;
        lateNow = frame_start && !hold;
      end
      WRITE: begin
        if (wr_valid && wr_last) stateD = READY;
        lateNow = frame_start && !hold;
      end
      READY: begin
        if (frame_start && !hold) begin
          stateD    = CLEAN;
          dispBankD = ~dispBank;
          swapNow   = 1'b1;
        end
      end
      default: stateD = CLEAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ   <= CLEAN;
      dispBank <= 1'b0;
      rdSel    <= 1'b0;
      swapCnt  <= '0;
      lateCnt  <= '0;
    end else begin
      stateQ   <= stateD;
      dispBank <= dispBankD;
      // Captures the bank that was displayed when the read was issued, so a
      // read in the swap cycle still returns the old bank's data.
      rdSel    <= dispBank;
      if (swapNow) swapCnt <= swapCnt + 1'b1;
      if (lateNow) lateCnt <= lateCnt + 1'b1;
    end
  end

  // Draw-bank port selection. The registered state gates engine traffic, so
  // beats presented in the wrong phase never reach the BRAM.
  always_comb begin
    drawEn   = 1'b0;
    drawWe   = 1'b0;
    drawAddr = '0;
    drawWd   = 1'b0;
    unique case (stateQ)
      CLEAN: begin
        drawEn   = clean_valid;
        drawWe   = clean_valid;
        drawAddr = clean_valid ? clean_addr : '0;
      end
      WRITE: begin
        drawEn   = wr_valid;
        drawWe   = wr_valid;
        drawAddr = wr_valid ? wr_addr : '0;
        drawWd   = wr_valid & wr_data;
      end
      default: ;
    endcase
  end

  // Bank mux. Outputs are forced low while reset is asserted so a reader
  // still driving rd_en cannot touch a BRAM before the scheduler is running.
  always_comb begin
    en0   = 1'b0;
    we0   = 1'b0;
    addr0 = '0;
    en1   = 1'b0;
    we1   = 1'b0;
    addr1 = '0;
    wd    = 1'b0;
    if (rst_n) begin
      wd = drawWd;
      if (!dispBank) begin
        en0   = rd_en;
        addr0 = rd_en ? rd_addr : '0;
        en1   = drawEn;
        we1   = drawWe;
        addr1 = drawAddr;
      end else begin
        en1   = rd_en;
        addr1 = rd_en ? rd_addr : '0;
        en0   = drawEn;
        we0   = drawWe;
        addr0 = drawAddr;
      end
    end
  end

  assign rd_data   = rst_n & (rdSel ? rd1 : rd0);
  assign clean_go  = (stateQ == CLEAN);
  assign write_go  = (stateQ == WRITE);
  assign disp_bank = dispBank;
  assign state     = stateQ;
  assign swap_cnt  = swapCnt;
  assign late_cnt  = lateCnt;

endmodule
